// File: rtl/lift_controller_core.sv
// Lift controller core: request latching, position tracking and the
// IDLE / MOVE / DOOR sequencing FSM for a single car.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   up_rqst      hall up-call buttons (level), one bit per floor
//   dn_rqst      hall down-call buttons (level), one bit per floor
//   flr_rqst     in-car floor buttons (level), one bit per floor
//   floor_sense  position sensor, one-hot at a floor, zero between floors
//   force_open   door-hold request (level)
//   direction    1 = up, 0 = down (registered)
//   motion       car commanded to move (registered)
//   door_open    door open (registered)
//
// state | meaning
// IDLE  | parked, doors closed, waiting for a request
// MOVE  | travelling in 'direction', checking each floor for a stop
// DOOR  | doors open, dwell timer running, serving the current floor
module lift_controller_core #(
   parameter int N_FLOORS         = 8,
   parameter int DOOR_OPEN_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] up_rqst,
   input  logic [N_FLOORS-1:0] dn_rqst,
   input  logic [N_FLOORS-1:0] flr_rqst,
   input  logic [N_FLOORS-1:0] floor_sense,
   input  logic                force_open,
   output logic                direction,
   output logic                motion,
   output logic                door_open
);

   localparam int FW = $clog2(N_FLOORS);
   localparam int CW = $clog2(DOOR_OPEN_CYCLES + 1);

   typedef logic [FW-1:0] flr_t;
   typedef logic [CW-1:0] cnt_t;
   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

   localparam cnt_t CNT_LOAD = cnt_t'(DOOR_OPEN_CYCLES - 1);

   // The top floor has no up call and the bottom floor has no down call.
   localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
   localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

   state_t              state, state_nxt;
   flr_t                cur_flr;
   logic [N_FLOORS-1:0] up_q, dn_q, flr_q;
   cnt_t                cnt, cnt_nxt;
   logic                dir_nxt;
   logic                door_first;

   logic                sense_hit;
   flr_t                sense_idx;
   logic [N_FLOORS-1:0] req_any;
   logic [N_FLOORS-1:0] cur_mask;
   logic                here, above, below;
   logic                stop_here;
   logic [N_FLOORS-1:0] up_clr, dn_clr, flr_clr;

   function automatic logic any_beyond(input logic [N_FLOORS-1:0] req,
                                       input flr_t f, input logic up);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (req[i] && (up ? (flr_t'(i) > f) : (flr_t'(i) < f))) hit = 1'b1;
      end
      return hit;
   endfunction

   // Lowest set sensor bit wins: scan downward so the last hit is the lowest.
   always_comb begin
      sense_hit = |floor_sense;
      sense_idx = '0;
      for (int i = N_FLOORS - 1; i >= 0; i--) begin
         if (floor_sense[i]) sense_idx = flr_t'(i);
      end
   end

   always_comb begin
      req_any   = up_q | dn_q | flr_q;
      cur_mask  = {{(N_FLOORS-1){1'b0}}, 1'b1} << cur_flr;
      here      = req_any[cur_flr];
      above     = any_beyond(req_any, cur_flr, 1'b1);
      below     = any_beyond(req_any, cur_flr, 1'b0);
      stop_here = flr_q[sense_idx]
                | (direction ? up_q[sense_idx] : dn_q[sense_idx])
                | !any_beyond(req_any, sense_idx, direction);
      flr_clr   = (state == DOOR) ? cur_mask : '0;
      up_clr    = (state == DOOR && direction)  ? cur_mask : '0;
      dn_clr    = (state == DOOR && !direction) ? cur_mask : '0;
   end

   always_comb begin
      state_nxt = state;
      dir_nxt   = direction;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (force_open || here) begin
               state_nxt = DOOR;
               cnt_nxt   = CNT_LOAD;
            end else if (above) begin
               state_nxt = MOVE;
               dir_nxt   = 1'b1;
            end else if (below) begin
               state_nxt = MOVE;
               dir_nxt   = 1'b0;
            end
         end
         MOVE: begin
            if (sense_hit && stop_here) begin
               state_nxt = DOOR;
               cnt_nxt   = CNT_LOAD;
            end
         end
         DOOR: begin
            // Evaluated in the first open cycle so the arrival-direction bit
            // is cleared first and the opposite bit on the following cycles.
            if (door_first && !any_beyond(req_any, cur_flr, direction)
                && (direction ? dn_q[cur_flr] : up_q[cur_flr]))
               dir_nxt = !direction;
            if (force_open) begin
               cnt_nxt = CNT_LOAD;
            end else if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - cnt_t'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cur_flr    <= '0;
         up_q       <= '0;
         dn_q       <= '0;
         flr_q      <= '0;
         cnt        <= '0;
         door_first <= 1'b0;
         direction  <= 1'b1;
         motion     <= 1'b0;
         door_open  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cur_flr    <= sense_hit ? sense_idx : cur_flr;
         up_q       <= (up_q  | (up_rqst & UP_MASK)) & ~up_clr;
         dn_q       <= (dn_q  | (dn_rqst & DN_MASK)) & ~dn_clr;
         flr_q      <= (flr_q | flr_rqst)            & ~flr_clr;
         cnt        <= cnt_nxt;
         door_first <= (state != DOOR) && (state_nxt == DOOR);
         direction  <= dir_nxt;
         motion     <= (state_nxt == MOVE);
         door_open  <= (state_nxt == DOOR);
      end
   end

endmodule

// File: tb/tb_lift_controller_core.sv
// Testbench for lift_controller_core: directed scenarios plus a randomized
// run, every cycle compared against a behavioural model of the car. A simple
// shaft model turns the expected motion into floor_sense (3 steps per floor).
module tb_lift_controller_core;

   localparam int N   = 8;
   localparam int DOC = 16;
   localparam int IDLE_M = 0, MOVE_M = 1, DOOR_M = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] up_rqst, dn_rqst, flr_rqst, floor_sense;
   logic         force_open;
   logic         direction, motion, door_open;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   bit mq_up[N], mq_dn[N], mq_fl[N];
   int m_floor, m_mode, m_left, m_age;
   bit m_dir;
   int pos;  // shaft position in thirds of a floor

   lift_controller_core #(.N_FLOORS(N), .DOOR_OPEN_CYCLES(DOC)) dut (
      .clk(clk), .reset(reset), .up_rqst(up_rqst), .dn_rqst(dn_rqst),
      .flr_rqst(flr_rqst), .floor_sense(floor_sense), .force_open(force_open),
      .direction(direction), .motion(motion), .door_open(door_open)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_req(input int i);
      return mq_up[i] | mq_dn[i] | mq_fl[i];
   endfunction

   function automatic bit m_beyond(input int f, input bit up);
      for (int i = 0; i < N; i++)
         if ((up ? (i > f) : (i < f)) && m_req(i)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      int sf, nmode, nleft, nage;
      bit ndir;
      bit nu[N], nd[N], nf[N];
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            mq_up[i] = 0; mq_dn[i] = 0; mq_fl[i] = 0;
         end
         m_floor = 0; m_dir = 1; m_mode = IDLE_M; m_left = 0; m_age = 0;
         return;
      end
      sf = -1;
      for (int i = N - 1; i >= 0; i--) if (floor_sense[i]) sf = i;
      nmode = m_mode; ndir = m_dir; nleft = m_left; nage = m_age + 1;
      case (m_mode)
         IDLE_M: begin
            if (force_open || m_req(m_floor)) begin
               nmode = DOOR_M; nleft = DOC; nage = 0;
            end else if (m_beyond(m_floor, 1)) begin
               nmode = MOVE_M; ndir = 1;
            end else if (m_beyond(m_floor, 0)) begin
               nmode = MOVE_M; ndir = 0;
            end
         end
         MOVE_M: begin
            if (sf >= 0 && (mq_fl[sf] || (m_dir ? mq_up[sf] : mq_dn[sf]) || !m_beyond(sf, m_dir))) begin
               nmode = DOOR_M; nleft = DOC; nage = 0;
            end
         end
         default: begin
            if (m_age == 0 && !m_beyond(m_floor, m_dir) && (m_dir ? mq_dn[m_floor] : mq_up[m_floor]))
               ndir = !m_dir;
            if (force_open) nleft = DOC;
            else begin
               nleft = m_left - 1;
               if (nleft == 0) nmode = IDLE_M;
            end
         end
      endcase
      for (int i = 0; i < N; i++) begin
         nu[i] = mq_up[i] | (up_rqst[i] && i != N - 1);
         nd[i] = mq_dn[i] | (dn_rqst[i] && i != 0);
         nf[i] = mq_fl[i] | flr_rqst[i];
         if (m_mode == DOOR_M && i == m_floor) begin
            nf[i] = 0;
            if (m_dir) nu[i] = 0; else nd[i] = 0;
         end
      end
      mq_up = nu; mq_dn = nd; mq_fl = nf;
      if (sf >= 0) m_floor = sf;
      m_mode = nmode; m_dir = ndir; m_left = nleft; m_age = nage;
   endtask

   task automatic update_sense();
      logic [N-1:0] one;
      one = 1;
      floor_sense = (pos % 3 == 0) ? (one << (pos / 3)) : '0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_val("direction", direction, m_dir);
      check_val("motion", motion, m_mode == MOVE_M);
      check_val("door_open", door_open, m_mode == DOOR_M);
      if (m_mode == MOVE_M) begin
         pos += m_dir ? 1 : -1;
         if (pos < 0) pos = 0;
         if (pos > 3 * (N - 1)) pos = 3 * (N - 1);
      end
      update_sense();
   endtask

   task automatic clear_inputs();
      up_rqst = '0; dn_rqst = '0; flr_rqst = '0; force_open = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      pos = 0;
      update_sense();
      tick();
      tick();
      check_val("rst_direction", direction, 1);
      check_val("rst_motion", motion, 0);
      check_val("rst_door_open", door_open, 0);
      reset = 1'b0;
   endtask

   // Runs until the door has opened and closed again; counts open and moving cycles.
   task automatic wait_door_cycle(input int budget, output int door_n, output int move_n);
      bit seen, done;
      door_n = 0; move_n = 0; seen = 0; done = 0;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (door_open) begin door_n++; seen = 1; end
         if (motion) move_n++;
         if (seen && !door_open) begin done = 1; break; end
      end
      check_val("door_cycle_timeout", done, 1);
   endtask

   initial begin
      int d, m, cnt;
      bit done;
      reset = 1'b1;
      clear_inputs();
      pos = 0;
      update_sense();

      // Parked at floor 0, no requests
      do_reset();
      repeat (20) tick();
      check_val("idle_motion", motion, 0);
      check_val("idle_door", door_open, 0);
      check_val("idle_direction", direction, 1);

      // Car call to floor 3 from floor 0
      flr_rqst[3] = 1'b1;
      tick();
      clear_inputs();
      wait_door_cycle(200, d, m);
      check_val("f3_door_cycles", d, DOC);
      check_val("f3_move_cycles", m, 9);
      repeat (10) tick();
      check_val("f3_idle_motion", motion, 0);
      check_val("f3_idle_door", door_open, 0);

      // Up and down call at 2, nothing above: reverse and clear both
      do_reset();
      up_rqst[2] = 1'b1;
      dn_rqst[2] = 1'b1;
      tick();
      clear_inputs();
      wait_door_cycle(200, d, m);
      check_val("rev_direction", direction, 0);
      check_val("rev_door_cycles", d, DOC);
      repeat (10) tick();
      check_val("rev_idle_door", door_open, 0);
      check_val("rev_idle_motion", motion, 0);

      // Door hold at floor 1 for 40 cycles
      do_reset();
      pos = 3;
      update_sense();
      tick();
      force_open = 1'b1;
      tick();
      cnt = door_open ? 1 : 0;
      repeat (40) begin
         tick();
         if (door_open) cnt++;
      end
      force_open = 1'b0;
      done = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (door_open) cnt++;
         else begin done = 1; break; end
      end
      check_val("hold_timeout", done, 1);
      check_val("hold_door_cycles", cnt, 40 + DOC);

      // force_open while moving is ignored
      flr_rqst[5] = 1'b1;
      tick();
      clear_inputs();
      done = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (motion) begin done = 1; break; end
      end
      check_val("move_start", done, 1);
      force_open = 1'b1;
      repeat (4) begin
         tick();
         check_val("force_in_move_door", door_open, 0);
      end
      force_open = 1'b0;
      wait_door_cycle(200, d, m);

      // Top-floor up call and bottom-floor down call are ignored
      do_reset();
      up_rqst[N-1] = 1'b1;
      dn_rqst[0]   = 1'b1;
      repeat (20) begin
         tick();
         check_val("ignored_motion", motion, 0);
         check_val("ignored_door", door_open, 0);
      end
      clear_inputs();

      // Reset mid-move abandons requests
      flr_rqst[6] = 1'b1;
      dn_rqst[4]  = 1'b1;
      tick();
      clear_inputs();
      repeat (5) tick();
      check_val("pre_reset_motion", motion, 1);
      reset = 1'b1;
      tick();
      check_val("mid_reset_motion", motion, 0);
      check_val("mid_reset_direction", direction, 1);
      check_val("mid_reset_door", door_open, 0);
      reset = 1'b0;
      pos = 0;
      update_sense();
      repeat (10) tick();
      check_val("post_reset_motion", motion, 0);
      check_val("post_reset_door", door_open, 0);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         logic [N-1:0] one;
         one = 1;
         up_rqst  = ($urandom_range(0, 15) == 0) ? (one << $urandom_range(0, N - 1)) : '0;
         dn_rqst  = ($urandom_range(0, 15) == 0) ? (one << $urandom_range(0, N - 1)) : '0;
         flr_rqst = ($urandom_range(0, 11) == 0) ? (one << $urandom_range(0, N - 1)) : '0;
         if ($urandom_range(0, 39) == 0) force_open = ~force_open;
         tick();
      end
      clear_inputs();
      repeat (5) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lift_controller_core.md
LIFT_CONTROLLER_CORE -- requirements
Module: lift_controller_core

Interface
REQ-001 Parameter N_FLOORS, default 8: number of floors, indexed 0 (bottom) to N_FLOORS-1 (top); minimum 2.
REQ-002 Parameter DOOR_OPEN_CYCLES, default 16: door dwell time in clock cycles; minimum 1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 up_rqst  input  N_FLOORS  hall up-call buttons, level, one bit per floor.
REQ-006 dn_rqst  input  N_FLOORS  hall down-call buttons, level, one bit per floor.
REQ-007 flr_rqst  input  N_FLOORS  in-car floor buttons, level, one bit per floor.
REQ-008 floor_sense  input  N_FLOORS  position sensor; one-hot when the car is aligned with a floor, all-zero between floors.
REQ-009 force_open  input  1  door-hold request, level.
REQ-010 direction  output  1  1 = up, 0 = down; registered.
REQ-011 motion  output  1  1 = car commanded to move; registered.
REQ-012 door_open  output  1  1 = door open; registered.

Function
REQ-013 Position register cur_flr SHALL load the index of the set floor_sense bit each cycle; lowest index wins if several bits are set; value held while floor_sense is zero.
REQ-014 Request queues up_q, dn_q, flr_q SHALL set bit i one cycle after the matching input bit i is high; set is sticky until cleared.
REQ-015 up_rqst[N_FLOORS-1] and dn_rqst[0] SHALL be ignored.
REQ-016 Derived terms: req_any[i] = up_q[i] | dn_q[i] | flr_q[i]; above = any req_any above cur_flr; below = any req_any below cur_flr; here = req_any[cur_flr].
REQ-017 The FSM SHALL have states IDLE, MOVE and DOOR; motion is 1 only in MOVE; door_open is 1 only in DOOR.
REQ-018 IDLE: if here, go to DOOR; else if above, set direction=1 and go to MOVE; else if below, set direction=0 and go to MOVE; else remain in IDLE. Transitions take one cycle.
REQ-019 MOVE stop condition: at floor f (floor_sense one-hot), stop if flr_q[f] is set, or the queue bit matching direction at f is set, or no req_any lies beyond f in direction. On stop, go to DOOR with motion=0 on the next edge.
REQ-020 In MOVE with floor_sense all-zero, the FSM SHALL hold state.
REQ-021 DOOR: door_open=1 for DOOR_OPEN_CYCLES cycles via a down-counter loaded on entry.
REQ-022 On DOOR entry, if no req_any lies beyond cur_flr in direction and the opposite-direction bit at cur_flr is set, direction SHALL invert.
REQ-023 In DOOR, each cycle the FSM SHALL clear flr_q[cur_flr] and the direction-matching queue bit at cur_flr; clear wins over a simultaneous set of that bit.
REQ-024 force_open=1 in DOOR SHALL reload the counter, holding the door open.
REQ-025 force_open=1 in IDLE SHALL enter DOOR.
REQ-026 force_open SHALL be ignored in MOVE.
REQ-027 On counter expiry with force_open=0, the FSM SHALL go to IDLE and door_open falls on the same edge.
REQ-028 door_open and motion SHALL never both be 1.

Reset
REQ-029 Reset SHALL have priority over all other inputs.
REQ-030 Reset SHALL set all queues=0, cur_flr=0, direction=1, motion=0, door_open=0 and state=IDLE.
REQ-031 Reset mid-move or mid-dwell SHALL abandon all pending requests.

Verification
REQ-032 Reset, then floor_sense=0b00000001 with no requests -> motion=0, door_open=0, direction=1 indefinitely.
REQ-033 At floor 0, pulse flr_rqst[3] -> direction=1, motion=1; drive floor_sense through floors 1 and 2 -> motion stays 1; floor_sense=bit3 -> motion=0, door_open=1 for 16 cycles, flr_q[3] cleared, then IDLE.
REQ-034 Car moving up from 0 with up_q[2] and dn_q[2] set and no request above 2 -> stops at 2, direction inverts to 0, both bits cleared.
REQ-035 Car at 1 with door open, force_open held 40 cycles -> door_open=1 for 40+16 cycles; force_open during MOVE -> door_open stays 0.
REQ-036 up_rqst[top]=1 and dn_rqst[0]=1 only -> queues stay 0, no motion.
REQ-037 Assert reset during MOVE with pending requests -> next cycle motion=0, queues empty, direction=1.
